// File: rtl/zle_param.sv
// Zero run-length encoder: literals pass through, zero runs (1..2^CW-1) collapse to one run word, EOS flushes a pending run.
// Latency 1 cycle; one output register; i_b rises while the output is stalled or a second token is queued behind a run word.
module zle_param #(
    parameter int  DW = 3,
    parameter int  CW = 3,
    localparam int PW = (DW > CW) ? DW : CW,
    localparam int OW = 1 + PW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [DW-1:0] i_d,
    input  logic          i_e,
    input  logic          i_v,
    output logic          i_b,
    output logic [OW-1:0] o_d,
    output logic          o_e,
    output logic          o_v,
    input  logic          o_b
);

    localparam logic [CW-1:0] MAX    = '1;
    localparam logic [CW-1:0] MAX_M1 = MAX - CW'(1);

    typedef enum logic [1:0] {ST_START, ST_ZEROS, ST_HOLD} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            pend_eos_q, pend_eos_d;
    logic [DW-1:0]   pend_dat_q, pend_dat_d;
    logic [OW-1:0]   word_q, word_d;
    logic            eos_q, eos_d;
    logic            vld_q, vld_d;

    logic pend;
    logic slot_free;
    logic accept;
    logic zero_in;
    logic at_limit;

    assign pend      = (state_q == ST_HOLD);
    assign slot_free = !vld_q || !o_b;
    assign i_b       = reset || pend || (vld_q && o_b);
    assign accept    = i_v && !i_b;
    assign zero_in   = !i_e && (i_d == '0);
    assign at_limit  = (cnt_q == MAX_M1);

    assign o_d = word_q;
    assign o_e = eos_q;
    assign o_v = vld_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_START;
            cnt_q      <= '0;
            pend_eos_q <= 1'b0;
            pend_dat_q <= '0;
            word_q     <= '0;
            eos_q      <= 1'b0;
            vld_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_eos_q <= pend_eos_d;
            pend_dat_q <= pend_dat_d;
            word_q     <= word_d;
            eos_q      <= eos_d;
            vld_q      <= vld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_START, ST_ZEROS: begin
                if (accept) begin
                    if (zero_in) state_d = at_limit ? ST_START : ST_ZEROS;
                    else         state_d = (cnt_q == '0) ? ST_START : ST_HOLD;
                end
            end
            ST_HOLD: if (slot_free) state_d = ST_START;
            default: state_d = ST_START;
        endcase
    end

    // A run word is emitted first; the token that ended the run waits in pend_* for the next free slot.
    always_comb begin
        cnt_d      = cnt_q;
        pend_eos_d = pend_eos_q;
        pend_dat_d = pend_dat_q;
        word_d     = word_q;
        eos_d      = eos_q;
        vld_d      = slot_free ? 1'b0 : vld_q;
        if (state_q == ST_HOLD) begin
            if (slot_free) begin
                vld_d  = 1'b1;
                eos_d  = pend_eos_q;
                word_d = pend_eos_q ? '0 : {1'b0, PW'(pend_dat_q)};
            end
        end else if (accept) begin
            if (zero_in) begin
                if (at_limit) begin
                    vld_d  = 1'b1;
                    eos_d  = 1'b0;
                    word_d = {1'b1, PW'(MAX)};
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end else if (cnt_q == '0) begin
                vld_d  = 1'b1;
                eos_d  = i_e;
                word_d = i_e ? '0 : {1'b0, PW'(i_d)};
            end else begin
                vld_d      = 1'b1;
                eos_d      = 1'b0;
                word_d     = {1'b1, PW'(cnt_q)};
                cnt_d      = '0;
                pend_eos_d = i_e;
                pend_dat_d = i_d;
            end
        end
    end

endmodule

// File: tb/tb_zle_param.sv
// Directed bench for zle_param at DW=3/CW=3 and DW=8/CW=4; expected words queued per stimulus step, checked on consumption.
module tb_zle_param;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic [2:0] a_i_d;
    logic       a_i_e, a_i_v, a_i_b;
    logic [3:0] a_o_d;
    logic       a_o_e, a_o_v, a_o_b;

    logic [7:0] b_i_d;
    logic       b_i_e, b_i_v, b_i_b;
    logic [8:0] b_o_d;
    logic       b_o_e, b_o_v, b_o_b;

    int checks = 0;
    int errors = 0;

    logic [4:0] qa[$];
    logic [9:0] qb[$];

    zle_param #(.DW(3), .CW(3)) dut_a (
        .clock(clock), .reset(reset),
        .i_d(a_i_d), .i_e(a_i_e), .i_v(a_i_v), .i_b(a_i_b),
        .o_d(a_o_d), .o_e(a_o_e), .o_v(a_o_v), .o_b(a_o_b)
    );

    zle_param #(.DW(8), .CW(4)) dut_b (
        .clock(clock), .reset(reset),
        .i_d(b_i_d), .i_e(b_i_e), .i_v(b_i_v), .i_b(b_i_b),
        .o_d(b_o_d), .o_e(b_o_e), .o_v(b_o_v), .o_b(b_o_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // An empty queue yields a word no correct encoder can produce (EOS with nonzero payload).
    always @(negedge clock) begin
        if (!reset && a_o_v && !a_o_b) begin
            logic [4:0] exp_a;
            exp_a = (qa.size() != 0) ? qa.pop_front() : 5'b1_1111;
            chk("a_word", {27'd0, a_o_e, a_o_d}, {27'd0, exp_a});
        end
        if (!reset && b_o_v && !b_o_b) begin
            logic [9:0] exp_b;
            exp_b = (qb.size() != 0) ? qb.pop_front() : 10'b11_1111_1111;
            chk("b_word", {22'd0, b_o_e, b_o_d}, {22'd0, exp_b});
        end
    end

    task automatic send_a(input logic [2:0] d, input logic e);
        int   n;
        logic acc;
        n     = 0;
        acc   = 1'b0;
        a_i_d = d;
        a_i_e = e;
        a_i_v = 1'b1;
        do begin
            @(negedge clock);
            acc = !a_i_b;
            @(posedge clock);
            #1;
            n++;
        end while (!acc && n < 50);
        if (!acc) chk("a_accept_timeout", {31'd0, acc}, 32'd1);
        a_i_v = 1'b0;
        a_i_d = '0;
        a_i_e = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] d, input logic e);
        int   n;
        logic acc;
        n     = 0;
        acc   = 1'b0;
        b_i_d = d;
        b_i_e = e;
        b_i_v = 1'b1;
        do begin
            @(negedge clock);
            acc = !b_i_b;
            @(posedge clock);
            #1;
            n++;
        end while (!acc && n < 50);
        if (!acc) chk("b_accept_timeout", {31'd0, acc}, 32'd1);
        b_i_v = 1'b0;
        b_i_d = '0;
        b_i_e = 1'b0;
    endtask

    task automatic drain(input string tag);
        repeat (6) @(posedge clock);
        #1;
        chk(tag, qa.size() + qb.size(), 0);
    endtask

    initial begin
        reset = 1'b1;
        a_i_d = '0; a_i_e = 1'b0; a_i_v = 1'b0; a_o_b = 1'b0;
        b_i_d = '0; b_i_e = 1'b0; b_i_v = 1'b0; b_o_b = 1'b0;

        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset_o_v", {31'd0, a_o_v}, 32'd0);
        chk("reset_o_d", {28'd0, a_o_d}, 32'd0);
        chk("reset_o_e", {31'd0, a_o_e}, 32'd0);
        chk("reset_i_b", {31'd0, a_i_b}, 32'd1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("post_reset_i_b", {31'd0, a_i_b}, 32'd0);
        chk("post_reset_b_o_v", {31'd0, b_o_v}, 32'd0);
        @(posedge clock);
        #1;

        // 5,0,0,3 -> literal, run of 2, literal; HOLD costs one cycle
        qa.push_back(5'b0_0101);
        qa.push_back(5'b0_1010);
        qa.push_back(5'b0_0011);
        send_a(3'd5, 1'b0);
        send_a(3'd0, 1'b0);
        send_a(3'd0, 1'b0);
        send_a(3'd3, 1'b0);
        @(negedge clock);
        chk("hold_i_b_high", {31'd0, a_i_b}, 32'd1);
        @(posedge clock);
        #1;
        @(negedge clock);
        chk("hold_i_b_released", {31'd0, a_i_b}, 32'd0);
        drain("drain_basic");

        // nine zeros then EOS: MAX run, remainder run, EOS
        qa.push_back(5'b0_1111);
        qa.push_back(5'b0_1010);
        qa.push_back(5'b1_0000);
        repeat (9) send_a(3'd0, 1'b0);
        send_a(3'd0, 1'b1);
        drain("drain_nine_zeros");

        // EOS from START then a fresh stream
        qa.push_back(5'b1_0000);
        qa.push_back(5'b0_0100);
        send_a(3'd0, 1'b1);
        send_a(3'd4, 1'b0);
        drain("drain_eos_start");

        // downstream stall for three cycles
        a_o_b = 1'b1;
        qa.push_back(5'b0_0001);
        send_a(3'd1, 1'b0);
        repeat (3) begin
            @(negedge clock);
            chk("stall_o_v", {31'd0, a_o_v}, 32'd1);
            chk("stall_o_d", {27'd0, a_o_e, a_o_d}, 32'h01);
            chk("stall_i_b", {31'd0, a_i_b}, 32'd1);
            @(posedge clock);
            #1;
        end
        a_o_b = 1'b0;
        qa.push_back(5'b0_0010);
        send_a(3'd2, 1'b0);
        drain("drain_stall");

        // reset mid-run discards the pending count
        repeat (4) send_a(3'd0, 1'b0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        qa.push_back(5'b0_0110);
        send_a(3'd6, 1'b0);
        drain("drain_reset_mid_run");

        // wide instance: fifteen zeros saturate the 4-bit count
        qb.push_back({1'b0, 1'b1, 8'h0F});
        repeat (15) send_b(8'h00, 1'b0);
        @(negedge clock);
        chk("b_max_run_visible", {31'd0, b_o_v}, 32'd1);
        @(posedge clock);
        #1;
        qb.push_back({1'b0, 1'b1, 8'h01});
        qb.push_back({1'b1, 9'h000});
        send_b(8'h00, 1'b0);
        send_b(8'h00, 1'b1);
        qb.push_back({1'b0, 1'b0, 8'hA5});
        send_b(8'hA5, 1'b0);
        drain("drain_wide");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/zle_param.md
# zle_param

Parametrised zero run-length encoder for the ZLE stream family. It widens the fixed 3-bit-in / 4-bit-out encoder to configurable data and run-count widths, and adds explicit end-of-stream handling that flushes a pending zero run. It sits between an upstream producer and downstream consumer, using the codebase's valid/back-pressure stream handshake on both sides.

## Interface
- `DW`, 3: input data width.
- `CW`, 3: run-count width; maximum run length `MAX = 2^CW - 1`.
- `OW`, derived localparam, 1 + max(DW, CW): output word width, `{tag, payload}`.
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `i_d`  in  DW  input token data.
- `i_e`  in  1  input token is end-of-stream (EOS); `i_d` is ignored when set.
- `i_v`  in  1  input token valid.
- `i_b`  out  1  back-pressure to the upstream producer.
- `o_d`  out  OW  output word: tag 0 = literal (payload = zero-extended `i_d`); tag 1 = zero run (payload = run length 1..MAX, zero-extended).
- `o_e`  out  1  output word is EOS (`o_d` = 0).
- `o_v`  out  1  output valid.
- `o_b`  in  1  back-pressure from the downstream consumer.

## Operation
- Input accepted on an edge where `i_v && !i_b`. Output consumed on an edge where `o_v && !o_b`.
- Single output register (`o_d`, `o_e`, `o_v`). Slot free = `!o_v || !o_b`.
- `i_b = reset || pend || (o_v && o_b)`. This is combinational from registers and `o_b`; there is no other path.
- Registers: `cnt` (CW bits, pending zero count), `pend` flag, `pend_kind` (literal or EOS), `pend_d` (DW).
- FSM states:
  - START: `cnt == 0`, no pend.
  - ZEROS: `cnt > 0`, no pend.
  - HOLD: pend set; run token in flight, second token queued.
- Accepted zero literal (`i_d == 0`, `!i_e`):
  - If `cnt == MAX-1`: load run token `{1, MAX}`, set `cnt = 0`, go to START.
  - Otherwise: `cnt++`, go to ZEROS, no output.
- Accepted nonzero literal:
  - From START: load `{0, i_d}`.
  - From ZEROS: load `{1, cnt}`, save `i_d` into `pend_d`, go to HOLD, `cnt = 0`.
- Accepted EOS:
  - From START: load EOS word (`o_e = 1`, `o_d = 0`).
  - From ZEROS: load `{1, cnt}`, queue EOS, go to HOLD, `cnt = 0`.
- HOLD: when the slot is free, load the queued token (literal or EOS) and go to START. No input is accepted in HOLD.
- "Load" means: `o_v <= 1` with the new word. If the slot is free and nothing is loaded, `o_v <= 0`.
- Zero runs never exceed MAX. A run of N zeros emits `floor(N/MAX)` MAX-tokens plus a remainder token when the run ends.
- After EOS the block returns to START. A new stream may begin the next cycle.

## Timing
- Reset (synchronous, active-high) values: `o_v = 0`, `o_d = 0`, `o_e = 0`, `cnt = 0`, `pend = 0`, state START. `i_b = 1` while `reset` is high, 0 on the first cycle after.
- Reset mid-run or mid-HOLD discards the pending count and queued token; no run token is emitted.
- Latency: an accepted token that loads output at edge k is visible on `o_d`/`o_v` in cycle k+1.
- HOLD costs exactly one extra cycle when `o_b = 0`: run token at k+1, queued token at k+2, input accepted again at k+2.
- Throughput is one token per cycle when there are no literal-after-run transitions and `o_b = 0`.
- Stall: while `o_v && o_b`, `o_d` and `o_e` are held stable and `i_b = 1`.
- Simultaneous consume-and-load on the same edge is allowed, so there is no bubble.
- A zero input at `cnt == MAX-1` while the slot is busy is not accepted, because `i_b` is high.

## Test plan
- DW=3, CW=3, `o_b = 0`: inputs 5,0,0,3 → `o_d` = 0_101, 1_010, 0_011. `i_b` is high for exactly one cycle after 3 is accepted.
- DW=3, CW=3: nine zeros then EOS → `1_111` on the 7th zero, then `1_010`, then EOS (`o_e = 1`, `o_d = 0`). Total 3 words, no spurious output.
- EOS from START → single EOS word. Next cycle, literal 4 → `0_100`.
- Back-pressure: hold `o_b = 1` for 3 cycles while `o_v = 1` → `o_d` stable and `i_b = 1` throughout. Release `o_b` → word consumed, next word follows with no loss or duplication.
- Reset during ZEROS with `cnt = 4`, then literal 6 → only `0_110` is emitted; no run token.
- DW=8, CW=4: fifteen `0x00` inputs → one word `{1, 8'h0F}` (OW=9), emitted on the 15th zero. `cnt` returns to 0.
